// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART FSM state encoding and parity-type constants.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_edge_bit_counter
// Purpose  : Per-bit clock-edge counter and data-bit index counter for uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_edge_bit_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int width      = 6
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             i_active,
    input  logic             i_data_phase,
    input  logic [width-1:0] i_p_lat,
    output logic             o_edge_last,
    output logic             o_bit_last
);

    localparam int                 c_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [width-1:0]   c_EDGE_ONE = width'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

    logic [width-1:0]   r_edge_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;

    // i_p_lat is never zero while active, so the subtraction cannot wrap.
    assign o_edge_last = (r_edge_cnt == (i_p_lat - c_EDGE_ONE));
    assign o_bit_last  = (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (RST || !i_active) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (o_edge_last) begin
            r_edge_cnt <= '0;
            if (i_data_phase) begin
                r_bit_cnt <= o_bit_last ? '0 : (r_bit_cnt + c_BIT_ONE);
            end
        end else begin
            r_edge_cnt <= r_edge_cnt + c_EDGE_ONE;
        end
    end

endmodule : uart_tx_edge_bit_counter
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter: start, LSB-first data, optional parity, stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int width      = 6
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [width-1:0]      Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam logic [width-1:0] c_ONE = width'(1);

    uart_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic [width-1:0]      r_p_lat;
    logic                  r_tx_out;
    logic                  r_busy;

    logic                  w_edge_last;
    logic                  w_bit_last;
    logic [width-1:0]      w_p_lat_next;
    logic                  w_parity;

    assign w_p_lat_next = (Prescale == '0) ? c_ONE : Prescale;
    // Parity is resolved at latch time because the data register shifts out.
    assign w_parity     = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

    uart_tx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .width      (width)
    ) u_counter (
        .clk          (clk),
        .RST          (RST),
        .i_active     (r_state != IDLE),
        .i_data_phase (r_state == DATA),
        .i_p_lat      (r_p_lat),
        .o_edge_last  (w_edge_last),
        .o_bit_last   (w_bit_last)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_p_lat   <= '0;
            r_tx_out  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Data_Valid) begin
                        r_shift   <= P_DATA;
                        r_par_en  <= PAR_EN;
                        r_par_bit <= w_parity;
                        r_p_lat   <= w_p_lat_next;
                        r_state   <= START;
                        r_tx_out  <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_edge_last) begin
                        r_state  <= DATA;
                        r_tx_out <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_edge_last) begin
                        if (!w_bit_last) begin
                            r_tx_out <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end else if (r_par_en) begin
                            r_state  <= PARITY;
                            r_tx_out <= r_par_bit;
                        end else begin
                            r_state  <= STOP;
                            r_tx_out <= 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_edge_last) begin
                        r_state  <= STOP;
                        r_tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_edge_last) begin
                        r_state  <= IDLE;
                        r_tx_out <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tx_out <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx_out;
    assign busy   = r_busy;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a frame-level queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic       clk        = 1'b0;
    logic       RST        = 1'b1;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN     = 1'b0;
    logic       PAR_TYP    = 1'b0;
    logic [7:0] P_DATA     = 8'h00;
    logic [5:0] Prescale   = 6'd8;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .DATA_WIDTH (8),
        .width      (6)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: a frame is a list of serial bits, each repeated P times with busy=1,
    // followed by one mandatory idle cycle before a new request is accepted.
    logic [1:0] mq[$];
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;

    always @(posedge clk) begin : model
        int   p;
        logic bits[$];
        if (RST) begin
            mq.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            if (mq.size() == 0 && Data_Valid) begin
                bits.delete();
                p = (Prescale == 0) ? 1 : int'(Prescale);
                bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) bits.push_back(P_DATA[i]);
                if (PAR_EN) bits.push_back((^P_DATA) ^ PAR_TYP);
                bits.push_back(1'b1);
                foreach (bits[k])
                    for (int c = 0; c < p; c++) mq.push_back({1'b1, bits[k]});
                mq.push_back(2'b01);
            end
            if (mq.size() > 0) begin
                {exp_busy, exp_tx} = mq.pop_front();
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (TX_OUT !== exp_tx || busy !== exp_busy) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t: got tx=%b busy=%b expected tx=%b busy=%b",
                     $time, TX_OUT, busy, exp_tx, exp_busy);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps);
        @(posedge clk); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
    endtask

    // Counts busy cycles of the current frame and samples each bit mid-period.
    task automatic capture(input int p, output int nbusy, output logic [11:0] bits);
        nbusy = 0;
        bits  = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if ((nbusy % p) == (p / 2) && (nbusy / p) < 12) bits[nbusy / p] = TX_OUT;
            nbusy++;
        end
    endtask

    function automatic logic [5:0] pick_prescale();
        case ($urandom_range(0, 5))
            0:       return 6'd8;
            1:       return 6'd16;
            2:       return 6'd32;
            3:       return 6'd0;
            4:       return 6'd1;
            default: return 6'd3;
        endcase
    endfunction

    initial begin
        int          n1, n2;
        logic [11:0] b1, b2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        RST = 1'b0;

        start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
        capture(8, n1, b1);
        check("a5_busy_len", n1, 80);
        check("a5_bits", {22'd0, b1[9:0]}, {22'd0, 10'b1101001010});

        start_frame(8'h03, 1'b1, 1'b0, 6'd16);
        capture(16, n1, b1);
        check("even_busy_len", n1, 176);
        check("even_bits", {21'd0, b1[10:0]}, {21'd0, 11'b10000000110});

        start_frame(8'h03, 1'b1, 1'b1, 6'd32);
        capture(32, n1, b1);
        check("odd_busy_len", n1, 352);
        check("odd_bits", {21'd0, b1[10:0]}, {21'd0, 11'b11000000110});

        start_frame(8'h5A, 1'b0, 1'b0, 6'd8);
        fork
            capture(8, n1, b1);
            begin
                repeat (20) @(posedge clk);
                #1;
                P_DATA = 8'hFF; Prescale = 6'd32; PAR_EN = 1'b1;
            end
        join
        check("midchg_busy_len", n1, 80);
        check("midchg_bits", {22'd0, b1[9:0]}, {22'd0, 10'b1010110100});

        @(posedge clk); #1;
        P_DATA = 8'h55; Prescale = 6'd8; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(posedge clk); #1;
        P_DATA = 8'hAA;
        fork
            begin
                capture(8, n1, b1);
                capture(8, n2, b2);
            end
            begin
                repeat (100) @(posedge clk);
                #1;
                Data_Valid = 1'b0;
            end
        join
        check("b2b_first_len", n1, 80);
        check("b2b_first_bits", {22'd0, b1[9:0]}, {22'd0, 10'b1010101010});
        check("b2b_second_len", n2, 80);
        check("b2b_second_bits", {22'd0, b2[9:0]}, {22'd0, 10'b1101010100});

        start_frame(8'hC3, 1'b0, 1'b0, 6'd8);
        repeat (34) @(posedge clk);
        #1;
        RST = 1'b1; Data_Valid = 1'b1;
        @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        RST = 1'b0; Data_Valid = 1'b0;
        @(negedge clk);
        check("abort_tx", {31'd0, TX_OUT}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {30'd0, busy, TX_OUT}, 32'd1);
        start_frame(8'hC3, 1'b0, 1'b0, 6'd8);
        capture(8, n1, b1);
        check("post_abort_len", n1, 80);
        check("post_abort_bits", {22'd0, b1[9:0]}, {22'd0, 10'b1110000110});

        for (int cyc = 0; cyc < 15000; cyc++) begin
            @(posedge clk); #1;
            RST        = ($urandom_range(0, 999) == 0);
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            Prescale   = pick_prescale();
        end
        @(posedge clk); #1;
        RST = 1'b0; Data_Valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter width, default 6, meaning Prescale bit width.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port P_DATA, input, DATA_WIDTH, parallel payload to send.
REQ-006 SHALL have port Data_Valid, input, 1, request to send P_DATA.
REQ-007 SHALL have port PAR_EN, input, 1, 1 = parity bit inserted.
REQ-008 SHALL have port PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
REQ-009 SHALL have port Prescale, input, width, clk cycles per serial bit; 8, 16 or 32 supported.
REQ-010 SHALL have port TX_OUT, output, 1, registered serial line, idle high.
REQ-011 SHALL have port busy, output, 1, registered, high while a frame is in progress.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE with Data_Valid=1: latch P_DATA, PAR_EN, PAR_TYP and Prescale; go to START; inputs ignored in all other states.
REQ-014 Latency: Data_Valid sampled high at edge N -> TX_OUT=0 and busy=1 from edge N+1.
REQ-015 Each state except IDLE SHALL hold TX_OUT for exactly P_lat clk cycles, P_lat = latched Prescale; latched 0 treated as 1.
REQ-016 An edge counter (width bits) SHALL count 0..P_lat-1 per bit, clear on bit change, and advance state at P_lat-1.
REQ-017 START SHALL drive 0.
REQ-018 DATA SHALL drive latched data LSB first; a bit counter counts 0..DATA_WIDTH-1.
REQ-019 After the last data bit, go to PARITY if latched PAR_EN=1, else STOP.
REQ-020 PARITY SHALL drive XOR of latched data for even, inverted XOR for odd.
REQ-021 STOP SHALL drive 1; at its end go to IDLE with busy=0 on the same edge TX_OUT stays 1.
REQ-022 IDLE SHALL last at least one cycle between frames; Data_Valid held high sends back-to-back frames with exactly one idle clk of TX_OUT=1 between them.
REQ-023 Frame length SHALL be (1+DATA_WIDTH+PAR_EN+1)*P_lat cycles of busy=1.
REQ-024 Changes on P_DATA, PAR_EN, PAR_TYP or Prescale while busy=1 SHALL NOT affect the current frame.

Reset
REQ-025 RST=1 at a clock edge SHALL force IDLE, TX_OUT=1, busy=0, and clear all counters and latched data.
REQ-026 RST asserted mid-frame SHALL abort the frame immediately with no partial stop bit; the next frame starts only after RST=0 and a new Data_Valid.
REQ-027 Data_Valid sampled on the same edge as RST=1 SHALL be ignored.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state typedef and the PAR_EVEN/PAR_ODD constants, for reuse by the receiver.
REQ-029 The edge and bit counters SHALL form one sub-module, uart_tx_edge_bit_counter; FSM, parity and output mux stay in uart_tx.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=0, Prescale=8 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,1, each 8 clk; busy high 80 clk.
REQ-031 P_DATA=0x03, PAR_EN=1, PAR_TYP=0, Prescale=16 -> parity bit 0; busy high 176 clk.
REQ-032 P_DATA=0x03, PAR_EN=1, PAR_TYP=1, Prescale=32 -> parity bit 1; busy high 352 clk.
REQ-033 Data_Valid held high, 0x55 then 0xAA, Prescale=8 -> two frames, one clk TX_OUT=1 idle between, busy low exactly 1 clk.
REQ-034 RST pulsed 1 clk during DATA bit 3 -> next edge TX_OUT=1, busy=0; no stop bit; a later Data_Valid sends a full frame.
REQ-035 P_DATA and Prescale changed to 0xFF/32 mid-frame -> current frame unaltered; edge counter ≤ P_lat-1 at all times.
